hw_stack: RTL and testbench
===========================

Name: hw_stack

Overview:
- Parametrised hardware LIFO for the CPU call/data stack.
- Wraps a synchronous-write, asynchronous-read word array with an internal stack pointer, push/pop handshake, full/empty status and sticky error flags.
- The CPU no longer computes stack addresses: it issues push/pop and always sees top-of-stack on data_out.

Parameters:
- WIDTH, 16, data word width in bits.
- NWORDS, 1024, stack depth in words; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write data_in onto the stack this cycle.
- pop  input  1  remove the top-of-stack entry this cycle.
- flush  input  1  synchronous stack clear.
- data_in  input  WIDTH  word to push.
- data_out  output  WIDTH  current top-of-stack, combinational from the array.
- sp  output  $clog2(NWORDS)+1  entry count, 0..NWORDS.
- empty  output  1  sp == 0.
- full  output  1  sp == NWORDS.
- overflow  output  1  sticky: push was attempted while full.
- underflow  output  1  sticky: pop was attempted while empty.

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and has the highest priority.
- Reset values:
  - sp = 0, empty = 1, full = 0, overflow = 0, underflow = 0, data_out = 0.
  - Array contents are not cleared.
- data_out:
  - Equals mem[sp-1] when sp > 0, else 0.
  - Purely combinational from sp and the array, so no read latency.
- Operation per cycle, with priority reset > flush > push/pop:
  - flush: sp <- 0 and overflow/underflow cleared. push/pop in the same cycle are ignored.
  - push only, not full: mem[sp] <- data_in, sp <- sp+1. New word is on data_out after the edge (1-cycle latency).
  - push only, full: no write, sp unchanged, overflow <- 1.
  - pop only, not empty: sp <- sp-1. The value on data_out during the pop cycle is the consumed word.
  - pop only, empty: sp stays 0, underflow <- 1.
  - push and pop, not empty (including full): replace top, mem[sp-1] <- data_in, sp unchanged, no error flags.
  - push and pop, empty: push performed (mem[0] <- data_in, sp <- 1), underflow <- 1.
  - Neither asserted: hold.
- Status outputs:
  - empty and full are decoded combinationally from sp.
  - sp never exceeds NWORDS and never wraps.
- Error flags:
  - overflow and underflow are sticky until reset or flush.
  - Both may be set at once.
  - They never block further operations.
- Reset or flush mid-sequence: any push/pop in that cycle is discarded; the next cycle starts from empty.
- The array write-enable is gated internally. A push rejected for full never corrupts the array.

Optional Feature:
- Macro: HW_STACK_WATERMARK_EN.
- Defined:
  - Adds output port hwm [$clog2(NWORDS):0], the high-water mark: the maximum sp reached since the last reset or flush.
  - Registered and updated on the same edge as sp, i.e. hwm <- max(hwm, next sp).
  - Reset and flush drive hwm to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- NWORDS=4. Reset, push 0x1111, 0x2222, 0x3333 on consecutive cycles -> sp=3, data_out=0x3333, empty=0, full=0.
- From that state, pop 3 times -> data_out shows 0x3333, 0x2222, 0x1111 in the pop cycles, then sp=0, data_out=0, empty=1, underflow=0.
- NWORDS=4. Push 5 words 0xA0..0xA4 -> sp=4, full=1, overflow=1, data_out=0xA3; array intact (pops return 0xA3, 0xA2, 0xA1, 0xA0).
- Empty stack, pop -> underflow=1, sp=0. Then push+pop with data_in 0x55 -> sp=1, data_out=0x55, underflow still 1. Then flush -> sp=0, underflow=0, overflow=0.
- sp=2, top 0x2222; push+pop with data_in 0xBEEF -> sp=2, data_out=0xBEEF, no flags. Then reset asserted together with push -> sp=0, empty=1, all flags 0.
- With HW_STACK_WATERMARK_EN: push 3, pop 2, push 1 -> hwm=3, sp=2. Flush -> hwm=0.

Source files
------------

// File: rtl/hw_stack.sv
// Parametrised hardware LIFO: word array plus internal stack pointer, full/empty and sticky error flags.
// Optional high-water-mark output enabled by defining HW_STACK_WATERMARK_EN.
module hw_stack #(
   parameter int WIDTH  = 16,
   parameter int NWORDS = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          data_in,
   output logic [WIDTH-1:0]          data_out,
   output logic [$clog2(NWORDS):0]   sp,
   output logic                      empty,
   output logic                      full,
   output logic                      overflow,
   output logic                      underflow
`ifdef HW_STACK_WATERMARK_EN
   ,
   output logic [$clog2(NWORDS):0]   hwm
`endif
);

   localparam int AW = $clog2(NWORDS);
   localparam logic [AW:0] SP_MAX = (AW+1)'(NWORDS);
   localparam logic [AW:0] SP_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [NWORDS];
   logic [AW:0]      r_sp;
   logic             r_overflow;
   logic             r_underflow;

   logic [AW:0]      w_sp_nxt;
   logic [AW:0]      w_sp_m1;
   logic [AW-1:0]    w_waddr;
   logic             w_we;
   logic             w_ovf_set;
   logic             w_unf_set;
   logic             w_clear;
   logic             w_empty;
   logic             w_full;

   assign w_empty = (r_sp == '0);
   assign w_full  = (r_sp == SP_MAX);
   assign w_sp_m1 = r_sp - SP_ONE;
   assign w_clear = reset | flush;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_sp_nxt  = r_sp;
      w_waddr   = r_sp[AW-1:0];
      w_we      = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (push && pop) begin
         w_we = 1'b1;
         if (w_empty) begin
            w_waddr   = '0;
            w_sp_nxt  = SP_ONE;
            w_unf_set = 1'b1;
         end else begin
            w_waddr = w_sp_m1[AW-1:0];
         end
      end else if (push) begin
         if (w_full) begin
            w_ovf_set = 1'b1;
         end else begin
            w_we     = 1'b1;
            w_sp_nxt = r_sp + SP_ONE;
         end
      end else if (pop) begin
         if (w_empty) begin
            w_unf_set = 1'b1;
         end else begin
            w_sp_nxt = w_sp_m1;
         end
      end
   end

   // NOTE: the array has no reset; contents survive reset/flush and are never read while empty.
   always_ff @(posedge clk) begin
      if (w_we && !w_clear) begin
         r_mem[w_waddr] <= data_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_sp        <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_sp        <= w_sp_nxt;
         r_overflow  <= r_overflow  | w_ovf_set;
         r_underflow <= r_underflow | w_unf_set;
      end
   end

`ifdef HW_STACK_WATERMARK_EN
   logic [AW:0] r_hwm;

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_hwm <= '0;
      end else if (w_sp_nxt > r_hwm) begin
         r_hwm <= w_sp_nxt;
      end
   end

   assign hwm = r_hwm;
`endif

   assign data_out  = w_empty ? '0 : r_mem[w_sp_m1[AW-1:0]];
   assign sp        = r_sp;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack (NWORDS=4): directed plan steps plus randomized traffic
// compared against a queue-based LIFO model.
module tb_hw_stack;

   localparam int WIDTH  = 16;
   localparam int NWORDS = 4;
   localparam int SPW    = $clog2(NWORDS) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             push;
   logic             pop;
   logic             flush;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [SPW-1:0]   sp;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
`ifdef HW_STACK_WATERMARK_EN
   logic [SPW-1:0]   hwm;
`endif

   hw_stack #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .data_in   (data_in),
      .data_out  (data_out),
      .sp        (sp),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
`ifdef HW_STACK_WATERMARK_EN
      ,
      .hwm       (hwm)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] m_q[$];
   bit               m_ovf;
   bit               m_unf;
   int               m_hwm;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_top();
      return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
   endfunction

   task automatic model_update(input bit p, input bit o, input bit f, input bit r,
                               input logic [WIDTH-1:0] d);
      if (r || f) begin
         m_q.delete();
         m_ovf = 0;
         m_unf = 0;
         m_hwm = 0;
      end else begin
         if (p && o) begin
            if (m_q.size() == 0) begin
               m_q.push_back(d);
               m_unf = 1;
            end else begin
               m_q[m_q.size()-1] = d;
            end
         end else if (p) begin
            if (m_q.size() == NWORDS) m_ovf = 1;
            else m_q.push_back(d);
         end else if (o) begin
            if (m_q.size() == 0) m_unf = 1;
            else void'(m_q.pop_back());
         end
         if (m_q.size() > m_hwm) m_hwm = m_q.size();
      end
   endtask

   task automatic check_state(input string ctx);
      check({ctx, " sp"},        32'(sp),        32'(m_q.size()));
      check({ctx, " data_out"},  32'(data_out),  32'(model_top()));
      check({ctx, " empty"},     32'(empty),     32'(m_q.size() == 0));
      check({ctx, " full"},      32'(full),      32'(m_q.size() == NWORDS));
      check({ctx, " overflow"},  32'(overflow),  32'(m_ovf));
      check({ctx, " underflow"}, 32'(underflow), 32'(m_unf));
`ifdef HW_STACK_WATERMARK_EN
      check({ctx, " hwm"},       32'(hwm),       32'(m_hwm));
`endif
   endtask

   // Drive one cycle from a negedge; data_out is checked before the edge (consumed word on pop)
   // and the full state after it.
   task automatic step(input string ctx, input bit p, input bit o, input bit f, input bit r,
                       input logic [WIDTH-1:0] d);
      push    = p;
      pop     = o;
      flush   = f;
      reset   = r;
      data_in = d;
      #1;
      if (!r) check({ctx, " pre-edge data_out"}, 32'(data_out), 32'(model_top()));
      @(posedge clk);
      model_update(p, o, f, r, d);
      @(negedge clk);
      check_state(ctx);
   endtask

   initial begin
      push = 0; pop = 0; flush = 0; reset = 1; data_in = '0;
      @(negedge clk);

      // Reset state
      step("reset", 0, 0, 0, 1, '0);
      check("reset empty const", 32'(empty), 32'd1);
      check("reset dout const", 32'(data_out), 32'd0);

      // Push three, pop three
      step("push1", 1, 0, 0, 0, 16'h1111);
      step("push2", 1, 0, 0, 0, 16'h2222);
      step("push3", 1, 0, 0, 0, 16'h3333);
      check("three pushed dout", 32'(data_out), 32'h3333);
      check("three pushed sp", 32'(sp), 32'd3);
      step("pop1", 0, 1, 0, 0, '0);
      step("pop2", 0, 1, 0, 0, '0);
      step("pop3", 0, 1, 0, 0, '0);
      check("drained empty", 32'(empty), 32'd1);

      // Overflow with intact array
      for (int i = 0; i < 5; i++) step($sformatf("fill%0d", i), 1, 0, 0, 0, 16'(16'hA0 + i));
      check("fill dout", 32'(data_out), 32'hA3);
      check("fill overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) step($sformatf("unfill%0d", i), 0, 1, 0, 0, '0);

      // Underflow, push+pop on empty, flush
      step("reset2", 0, 0, 0, 1, '0);
      step("pop empty", 0, 1, 0, 0, '0);
      check("pop empty underflow", 32'(underflow), 32'd1);
      step("pushpop empty", 1, 1, 0, 0, 16'h0055);
      check("pushpop empty dout", 32'(data_out), 32'h55);
      step("flush", 0, 0, 1, 0, '0);

      // Replace top, then reset together with push
      step("push a", 1, 0, 0, 0, 16'h1111);
      step("push b", 1, 0, 0, 0, 16'h2222);
      step("replace", 1, 1, 0, 0, 16'hBEEF);
      check("replace dout", 32'(data_out), 32'hBEEF);
      check("replace sp", 32'(sp), 32'd2);
      step("reset+push", 1, 0, 0, 1, 16'h7777);
      check("reset+push sp", 32'(sp), 32'd0);

      // Watermark sequence (also exercises model when feature absent)
      step("wm push1", 1, 0, 0, 0, 16'h0001);
      step("wm push2", 1, 0, 0, 0, 16'h0002);
      step("wm push3", 1, 0, 0, 0, 16'h0003);
      step("wm pop1", 0, 1, 0, 0, '0);
      step("wm pop2", 0, 1, 0, 0, '0);
      step("wm push4", 1, 0, 0, 0, 16'h0004);
`ifdef HW_STACK_WATERMARK_EN
      check("wm hwm const", 32'(hwm), 32'd3);
`endif
      step("wm flush", 0, 0, 1, 0, '0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rand%0d", i),
              bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)),
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 49) == 0),
              16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
